// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the icache (read-only)
// and the dcache (read/write). A grant is held for a whole block so fills and
// writebacks never interleave, and simultaneous requests alternate round-robin.
module mem_arbiter #(
  parameter int WORDS_PER_BLK = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // icache side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // sticky error flag
  output logic              err
);

  // One extra bit so the counter can never wrap inside a block.
  localparam int CNT_W = $clog2(WORDS_PER_BLK) + 1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_d_reg;  // 1: dcache was served last, 0: icache
  logic             err_reg;

  logic d_req;
  logic access;
  logic ram_error;
  logic blk_done;

  assign d_req     = dREN | dWEN;
  assign access    = (ramstate == RAM_ACCESS);
  assign ram_error = (ramstate == RAM_ERROR);
  assign blk_done  = access && (cnt_reg == CNT_W'(WORDS_PER_BLK - 1));

  // Grant sequencing, block word counting, round-robin history and error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_d_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (iREN && d_req)
            state_reg <= last_d_reg ? GRANT_I : GRANT_D;
          else if (iREN)
            state_reg <= GRANT_I;
          else if (d_req)
            state_reg <= GRANT_D;
        end
        GRANT_I: begin
          if (ram_error)
            err_reg <= 1'b1;
          // Dropping the request abandons the partial block.
          if (!iREN || blk_done) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            last_d_reg <= 1'b0;
          end else if (access) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        GRANT_D: begin
          if (ram_error)
            err_reg <= 1'b1;
          if (!d_req || blk_done) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            last_d_reg <= 1'b1;
          end else if (access) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // RAM steering and wait generation follow the current grant and live inputs.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_reg)
      GRANT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !access;
      end
      GRANT_D: begin
        // A write wins when the dcache raises both enables.
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !access;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; each cache only samples it while its wait is low.
  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a
// word-counting reference model of the arbiter.
module tb_mem_arbiter;

  localparam int WPB = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic          CLK;
  logic          RST;
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;
  logic          err;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .WORDS_PER_BLK(WPB),
    .ADDR_W       (AW),
    .DATA_W       (DW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Move to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Pulse reset for one cycle with all requests idle; returns just after release.
  task automatic do_reset;
    tick();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd2;
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0; ramload = $urandom;
    #4;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rst_ramREN got=%0h want=0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL rst_ramWEN got=%0h want=0", ramWEN); end
    checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL rst_ramaddr got=%0h want=0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin failures++; $display("FAIL rst_ramstore got=%0h want=0", ramstore); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL rst_waits got=%0h%0h want=11", iwait, dwait); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h want=0", err); end
    tick();
    RST = 1'b0;
    #4;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rel_no_enable got=%0h want=0", ramREN); end
    tick(); #4;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL c1_ramREN got=%0h want=1", ramREN); end
    checks++; if (ramaddr !== 32'h40) begin failures++; $display("FAIL c1_ramaddr got=%0h want=40", ramaddr); end
    checks++; if (iwait !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL c1_waits got=%0h%0h want=01", iwait, dwait); end
    checks++; if (iload !== ramload) begin failures++; $display("FAIL c1_iload got=%0h want=%0h", iload, ramload); end
    tick();
    iaddr = 32'h44;
    #4;
    checks++; if (iwait !== 1'b0) begin failures++; $display("FAIL c2_iwait got=%0h want=0", iwait); end
    checks++; if (ramaddr !== 32'h44) begin failures++; $display("FAIL c2_ramaddr got=%0h want=44", ramaddr); end
    tick();
    iREN = 1'b0;
    #4;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL c3_idle got=ren%0h iwait%0h want=ren0 iwait1", ramREN, iwait); end
    $display("test_reset done");
  endtask

  task automatic test_tie;
    logic [DW-1:0] st;
    do_reset();
    st = $urandom;
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = st; ramstate = 2'd2;
    #4;
    checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL tie_idle_wen got=%0h want=0", ramWEN); end
    for (int w = 0; w < WPB; w++) begin
      tick(); #4;
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL tie_d_en w=%0d got=wen%0h ren%0h want=wen1 ren0", w, ramWEN, ramREN); end
      checks++; if (ramstore !== dstore || ramaddr !== daddr) begin failures++; $display("FAIL tie_d_bus w=%0d got=%0h/%0h want=%0h/%0h", w, ramaddr, ramstore, daddr, dstore); end
      checks++; if (iwait !== 1'b1 || dwait !== 1'b0) begin failures++; $display("FAIL tie_d_waits w=%0d got=%0h%0h want=10", w, iwait, dwait); end
      daddr = daddr + 32'h4; dstore = $urandom;
    end
    tick();
    dWEN = 1'b0;
    #4;
    checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL tie_gap got=wen%0h ren%0h waits%0h%0h want=wen0 ren0 waits11", ramWEN, ramREN, iwait, dwait); end
    tick(); #4;
    checks++; if (ramREN !== 1'b1 || iwait !== 1'b0 || ramaddr !== 32'h80) begin failures++; $display("FAIL tie_then_i got=ren%0h iwait%0h addr%0h want=ren1 iwait0 addr80", ramREN, iwait, ramaddr); end
    iREN = 1'b0;
    $display("test_tie done");
  endtask

  task automatic test_alternate;
    int  phase, blk;
    bit  ei, ed;
    logic [AW-1:0] ea;
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300; ramstate = 2'd2;
    for (int k = 0; k < 4 * (WPB + 1); k++) begin
      tick(); #4;
      phase = k % (WPB + 1);
      blk   = k / (WPB + 1);
      ei = (phase != WPB) && (blk % 2 == 1);
      ed = (phase != WPB) && (blk % 2 == 0);
      ea = ei ? 32'h200 : (ed ? 32'h300 : 32'h0);
      checks++; if (iwait !== !ei || dwait !== !ed) begin failures++; $display("FAIL alt_waits k=%0d got=%0h%0h want=%0h%0h", k, iwait, dwait, !ei, !ed); end
      checks++; if (ramREN !== (ei || ed) || ramaddr !== ea) begin failures++; $display("FAIL alt_ram k=%0d got=ren%0h addr%0h want=ren%0h addr%0h", k, ramREN, ramaddr, ei || ed, ea); end
    end
    iREN = 1'b0; dREN = 1'b0;
    $display("test_alternate done");
  endtask

  task automatic test_busy;
    do_reset();
    dREN = 1'b1; daddr = 32'h500; ramstate = 2'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++; if (dwait !== 1'b1 || ramREN !== 1'b1) begin failures++; $display("FAIL busy_hold i=%0d got=dwait%0h ren%0h want=dwait1 ren1", i, dwait, ramREN); end
      tick();
    end
    ramstate = 2'd2;
    #4;
    checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL busy_first_word got=%0h want=0", dwait); end
    tick(); #4;
    checks++; if (dwait !== 1'b0 || ramREN !== 1'b1) begin failures++; $display("FAIL busy_second_word got=dwait%0h ren%0h want=dwait0 ren1", dwait, ramREN); end
    tick(); #4;
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL busy_done_idle got=ren%0h dwait%0h want=ren0 dwait1", ramREN, dwait); end
    dREN = 1'b0;
    $display("test_busy done");
  endtask

  task automatic test_drop;
    do_reset();
    iREN = 1'b1; iaddr = 32'h600; daddr = 32'h700; ramstate = 2'd2;
    tick(); #4;
    checks++; if (iwait !== 1'b0) begin failures++; $display("FAIL drop_word0 got=%0h want=0", iwait); end
    tick();
    iREN = 1'b0; dREN = 1'b1; ramstate = 2'd1;
    #4;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL drop_cycle got=ren%0h waits%0h%0h want=ren0 waits11", ramREN, iwait, dwait); end
    tick(); #4;
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL drop_idle got=ren%0h dwait%0h want=ren0 dwait1", ramREN, dwait); end
    ramstate = 2'd2;
    tick(); #4;
    checks++; if (ramREN !== 1'b1 || dwait !== 1'b0 || ramaddr !== 32'h700) begin failures++; $display("FAIL drop_then_d got=ren%0h dwait%0h addr%0h want=ren1 dwait0 addr700", ramREN, dwait, ramaddr); end
    dREN = 1'b0;
    $display("test_drop done");
  endtask

  task automatic test_error;
    do_reset();
    dWEN = 1'b1; daddr = 32'h800; dstore = 32'hdead_beef; ramstate = 2'd3;
    tick(); #4;
    checks++; if (dwait !== 1'b1 || ramWEN !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL err_first got=dwait%0h wen%0h err%0h want=dwait1 wen1 err0", dwait, ramWEN, err); end
    tick(); #4;
    checks++; if (err !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL err_set got=err%0h dwait%0h want=err1 dwait1", err, dwait); end
    ramstate = 2'd2;
    #1;
    checks++; if (dwait !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL err_access got=dwait%0h err%0h want=dwait0 err1", dwait, err); end
    tick();
    ramstate = 2'd1;
    #4;
    checks++; if (err !== 1'b1 || ramWEN !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL err_sticky_grant got=err%0h wen%0h dwait%0h want=err1 wen1 dwait1", err, ramWEN, dwait); end
    RST = 1'b1;
    #1;
    checks++; if (ramWEN !== 1'b0 || err !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL err_async_rst got=wen%0h err%0h dwait%0h want=wen0 err0 dwait1", ramWEN, err, dwait); end
    tick();
    RST = 1'b0; dWEN = 1'b0;
    $display("test_error done");
  endtask

  task automatic test_random;
    // Reference model: who owns the RAM, words finished in this block,
    // who was served last, and whether an error has been seen.
    int  owner;   // 0 none, 1 icache, 2 dcache
    int  words;
    bit  last_d;
    bit  m_err;
    bit  d_on;
    int  r;
    logic          e_ren, e_wen, e_iw, e_dw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store;
    do_reset();
    owner = 0; words = 0; last_d = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (iREN) iREN = ($urandom_range(0, 7) != 0);
      else      iREN = ($urandom_range(0, 1) == 1);
      d_on = dREN | dWEN;
      if (d_on) d_on = ($urandom_range(0, 7) != 0);
      else      d_on = ($urandom_range(0, 1) == 1);
      if (!d_on) begin
        dREN = 1'b0; dWEN = 1'b0;
      end else if (!(dREN | dWEN) || $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        dREN = (r != 1);
        dWEN = (r != 0);
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 19);
      ramstate = (r < 12) ? 2'd2 : (r < 16) ? 2'd1 : (r < 19) ? 2'd0 : 2'd3;
      #4;
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iw = 1'b1; e_dw = 1'b1;
      if (owner == 1) begin
        e_ren = iREN; e_addr = iaddr; e_iw = (ramstate != 2'd2);
      end else if (owner == 2) begin
        e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
        e_dw = (ramstate != 2'd2);
      end
      checks++; if (ramREN !== e_ren || ramWEN !== e_wen) begin failures++; $display("FAIL rnd_en n=%0d got=ren%0h wen%0h want=ren%0h wen%0h", n, ramREN, ramWEN, e_ren, e_wen); end
      checks++; if (ramaddr !== e_addr) begin failures++; $display("FAIL rnd_addr n=%0d got=%0h want=%0h", n, ramaddr, e_addr); end
      checks++; if (ramstore !== e_store) begin failures++; $display("FAIL rnd_store n=%0d got=%0h want=%0h", n, ramstore, e_store); end
      checks++; if (iwait !== e_iw || dwait !== e_dw) begin failures++; $display("FAIL rnd_waits n=%0d got=%0h%0h want=%0h%0h", n, iwait, dwait, e_iw, e_dw); end
      checks++; if (iload !== ramload || dload !== ramload) begin failures++; $display("FAIL rnd_load n=%0d got=%0h/%0h want=%0h", n, iload, dload, ramload); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%0h want=%0h", n, err, m_err); end
      if (!e_iw) $display("word n=%0d side=I addr=%0h data=%0h", n, iaddr, ramload);
      if (!e_dw) $display("word n=%0d side=D addr=%0h %s=%0h", n, daddr, dWEN ? "store" : "load", dWEN ? dstore : ramload);
      @(posedge CLK);
      if (owner == 0) begin
        words = 0;
        if (iREN && (dREN | dWEN)) owner = last_d ? 1 : 2;
        else if (iREN)             owner = 1;
        else if (dREN | dWEN)      owner = 2;
      end else begin
        if (ramstate == 2'd3) m_err = 1'b1;
        if ((owner == 1 && !iREN) || (owner == 2 && !(dREN | dWEN))) begin
          last_d = (owner == 2); owner = 0; words = 0;
        end else if (ramstate == 2'd2) begin
          words++;
          if (words == WPB) begin
            last_d = (owner == 2); owner = 0; words = 0;
          end
        end
      end
      #1;
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    test_reset();
    test_tie();
    test_alternate();
    test_busy();
    test_drop();
    test_error();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-ported RAM between the instruction cache (read-only) and the data cache (read/write).
- Holds a grant across a multi-word block transfer so cache fills and writebacks are not interleaved.
- Alternates round-robin between the two caches when both request.
- Sits between the icache/dcache and the RAM model, on the cache-control side of the memory hierarchy.

Parameters:
- WORDS_PER_BLK, 2, words per block transfer; the grant is held until this many words complete. Must be 1 or greater.
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  icache read request; held high for the whole block.
- iaddr  in  ADDR_W  icache word address; the icache advances it per word.
- iwait  out  1  low for exactly the cycle an icache word completes.
- iload  out  DATA_W  read data to icache; valid when iwait is low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly the cycle a dcache word completes.
- dload  out  DATA_W  read data to dcache; valid when dwait is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0=FREE, 1=BUSY, 2=ACCESS (word done this cycle), 3=ERROR.
- err  out  1  sticky flag, set when ERROR is seen during a grant.

Behaviour:
- Reset (RST high, asynchronous):
  - State goes to IDLE; word counter 0; last_served = I, so the dcache wins the first tie; err = 0.
  - All RAM outputs 0; iwait = dwait = 1.
  - Reset mid-burst abandons the transfer immediately. No RAM enable is asserted in the cycle after release.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - All RAM enables 0; ramaddr = 0; ramstore = 0; iwait = dwait = 1.
  - Next state: only iREN → GRANT_I; only dREN|dWEN → GRANT_D; both → the side not equal to last_served; neither → IDLE.
  - Word counter cleared.
  - Minimum request-to-completion latency: 1 cycle. Request seen in IDLE at cycle N; grant state at N+1; completion at N+1 if ramstate = ACCESS then.
- GRANT_I:
  - ramREN = iREN; ramWEN = 0; ramaddr = iaddr.
  - iwait = (ramstate != ACCESS); dwait = 1.
- GRANT_D:
  - If dWEN = 1: ramWEN = 1, ramREN = 0. dWEN has priority when dREN and dWEN are both high.
  - Otherwise ramREN = dREN.
  - ramaddr = daddr; ramstore = dstore.
  - dwait = (ramstate != ACCESS); iwait = 1.
- Word counting in a grant state:
  - On each ramstate = ACCESS cycle the counter increments.
  - When ACCESS occurs with counter == WORDS_PER_BLK-1: the transfer is complete. Next state IDLE, last_served = granted side, counter cleared.
  - Counter width is clog2(WORDS_PER_BLK)+1; it never wraps inside a grant.
- Early drop: if the granted requester deasserts all its enables before completion, go to IDLE next cycle, clear the counter and set last_served = that side. The partial burst is abandoned silently.
- Requester switching mid-grant: if the dcache switches between read and write during a grant, the new enable is passed through. The word count continues.
- BUSY or FREE during a grant: the granted wait stays high; the counter holds.
- ERROR during a grant:
  - Treated as a wait: no counter advance, wait stays high.
  - err is set and stays set until RST.
  - The grant is held; the requester or reset resolves it.
- Data paths: iload = ramload and dload = ramload, combinational and unconditional. Consumers sample only when their wait is low.
- One-cycle turnaround: IDLE always separates two grants, so back-to-back blocks from different caches are never merged.
- Output timing: all RAM and wait outputs are combinational from state and the current inputs. State, counter, last_served and err are registered.

Test Plan:
- Reset release with iREN=1, iaddr=0x40, ramstate=ACCESS on every cycle:
  - Cycle 1: GRANT_I, ramREN=1, ramaddr=0x40, iwait=0.
  - Cycle 2 (iaddr=0x44): iwait=0.
  - Cycle 3: IDLE with ramREN=0.
- iREN and dWEN rise together from IDLE after reset → GRANT_D first, with ramWEN=1, ramstore=dstore, iwait=1 throughout. After the dcache's 2 ACCESS cycles → IDLE → GRANT_I.
- Both caches request continuously for 4 blocks → grants alternate D,I,D,I. Each grant spans exactly 2 ACCESS cycles, with one IDLE between grants.
- In GRANT_D, ramstate = BUSY for 3 cycles and then ACCESS → dwait=1 for 3 cycles, then 0. Counter reads 0 during BUSY and 1 after the ACCESS.
- In GRANT_I after 1 word, iREN drops → IDLE next cycle. A following dREN is granted even though the dcache was not last served.
- ramstate=ERROR during GRANT_D → err=1 and dwait=1. err stays 1 after ramstate returns to ACCESS. Asserting RST mid-grant → IDLE, err=0, ramWEN=0 immediately (asynchronous).
